pcie_msg_reassembler: RTL
=========================

# pcie_msg_reassembler

Parametrised successor to the single-context PCIe message receiver. It accepts fragment headers and data beats for up to NUM_TAGS concurrently open messages, arriving in any order and interleaved across tags. Each beat is written into a per-tag SRAM region. When a message is complete it emits a one-cycle assembled pulse, so the AXI-to-SRAM read path can fetch it. It sits between the AXI write front end and the shared 256-bit SRAM.

## Interface
Parameters:
- DATA_WIDTH, 256, beat width
- NUM_TAGS, 16, concurrent reassembly contexts (power of 2); TAG_W = $clog2(NUM_TAGS)
- MAX_BEATS, 64, max beats per message (power of 2); BEAT_W = $clog2(MAX_BEATS)
- ADDR_WIDTH, 10, SRAM address width; NUM_TAGS*MAX_BEATS <= 2**ADDR_WIDTH
- TIMEOUT_CYCLES, 4096, per-tag inactivity limit (only used with the macro)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- hdr_valid  in  1  fragment header valid
- hdr_ready  out  1  header accepted when hdr_valid & hdr_ready
- hdr_tag  in  TAG_W  message tag
- hdr_offset  in  BEAT_W  beat offset of fragment within message
- hdr_len  in  BEAT_W+1  fragment length in beats, 1..MAX_BEATS
- hdr_last  in  1  final fragment of message
- d_valid  in  1  data beat valid
- d_ready  out  1  data beat accepted when d_valid & d_ready
- d_data  in  DATA_WIDTH  beat payload
- d_last  in  1  last beat of fragment
- sram_wen  out  1  SRAM write enable
- sram_waddr  out  ADDR_WIDTH  SRAM write address
- sram_wdata  out  DATA_WIDTH  SRAM write data
- asm_valid  out  1  one-cycle pulse: message complete
- asm_tag  out  TAG_W  completed tag
- asm_len  out  BEAT_W+1  total message beats
- err_valid  out  1  one-cycle error pulse
- err_tag  out  TAG_W  tag in error
- err_code  out  2  1 = overflow, 2 = length mismatch, 3 = timeout

## Operation
- Per-tag context: active, rcv_cnt (BEAT_W+1), total (BEAT_W+1), have_last.
- FSM states and transitions:
  - IDLE: hdr_ready = 1. On a header handshake, latch the header and go to CHECK.
  - CHECK (1 cycle): if offset+len > MAX_BEATS, flag overflow. Otherwise set active; if hdr_last, set total = offset+len and have_last. Go to DATA.
  - DATA: d_ready = 1. The i-th accepted beat (i from 0) writes address tag*MAX_BEATS + offset + i; overflowed fragments are drained with no writes. The fragment ends on d_last or on beat number len, whichever comes first. If the two do not coincide, flag a length mismatch. Go to DONE.
  - DONE (1 cycle): for a clean fragment, rcv_cnt += beats. If have_last and rcv_cnt == total: pulse asm (asm_len = total) and clear the context. If rcv_cnt > total: err code 2 and clear. Any flagged error: err pulse and clear the context. Go to IDLE.
- Fragments for one tag may arrive in any order. Duplicate coverage is only caught through the rcv_cnt > total check.
- Arithmetic is unsigned; offset+len is computed at BEAT_W+1 bits, so there is no wrap.

## Timing
- Reset:
  - All outputs are 0, including hdr_ready and d_ready.
  - The FSM goes to IDLE and all contexts and timers are cleared.
  - Reset mid-fragment abandons the fragment with no asm or err pulse.
- The header is accepted in cycle N, CHECK is N+1, and the first beat can be accepted in cycle N+2.
- SRAM write is registered: a beat accepted in cycle k gives sram_wen/addr/data in cycle k+1.
- The last beat accepted in cycle k gives DONE in k+1. asm_valid/err_valid assert in k+1, coinciding with the final sram_wen. hdr_ready returns in k+2.
- Minimum per-fragment cost: len+3 cycles.
- d_ready is 0 outside DATA; d_valid is ignored there.

## Configuration
- PCIE_REASM_TIMEOUT_EN defined:
  - Each active tag has a counter that increments every cycle and resets when the DONE state processes that tag.
  - At TIMEOUT_CYCLES the counter saturates and the tag pends a timeout.
  - In any cycle with no fragment err pulse, the lowest pending tag reports err_code 3 and its context is cleared.
  - If DONE and a timeout hit the same tag in the same cycle, DONE wins and the timer restarts.
- PCIE_REASM_TIMEOUT_EN undefined: no timers exist, contexts persist until completion or error, and err_code 3 is never produced.

## Test plan
- Tag 3, one fragment, offset 0, len 4, last -> 4 writes at 0xC0..0xC3, then asm_valid with tag 3, len 4 coinciding with the 4th sram_wen.
- Tag 1 fragments (offset 2, len 2, last) then (offset 0, len 2) -> writes at 0x42,0x43 then 0x40,0x41; asm once with len 4, only after the second fragment.
- Interleave tag 0 (offset 0, len 1) and tag 5 (offset 0, len 2, last), then tag 0 (offset 1, len 1, last) -> asm tag 5 len 2 first, then asm tag 0 len 2; no cross-tag writes.
- Tag 2 offset 60, len 8 -> beats drained, no sram_wen, err code 1 tag 2.
- Tag 4 len 3 with d_last on beat 2 -> 2 writes, err code 2 tag 4, context cleared.
- With PCIE_REASM_TIMEOUT_EN and TIMEOUT_CYCLES = 16: tag 7 non-last fragment, then idle -> err code 3 tag 7 sixteen cycles after its DONE.

Source files
------------

// File: rtl/pcie_msg_reassembler.sv
// Multi-tag PCIe message reassembler: writes fragment beats into per-tag SRAM regions and pulses on completion.
// Optional per-tag inactivity timeout enabled by defining PCIE_REASM_TIMEOUT_EN.
module pcie_msg_reassembler #(
  parameter int DATA_WIDTH     = 256,
  parameter int NUM_TAGS       = 16,
  parameter int MAX_BEATS      = 64,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int TAG_W         = $clog2(NUM_TAGS),
  localparam int BEAT_W        = $clog2(MAX_BEATS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hdr_valid,
  output logic                  hdr_ready,
  input  logic [TAG_W-1:0]      hdr_tag,
  input  logic [BEAT_W-1:0]     hdr_offset,
  input  logic [BEAT_W:0]       hdr_len,
  input  logic                  hdr_last,
  input  logic                  d_valid,
  output logic                  d_ready,
  input  logic [DATA_WIDTH-1:0] d_data,
  input  logic                  d_last,
  output logic                  sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_waddr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic                  asm_valid,
  output logic [TAG_W-1:0]      asm_tag,
  output logic [BEAT_W:0]       asm_len,
  output logic                  err_valid,
  output logic [TAG_W-1:0]      err_tag,
  output logic [1:0]            err_code
);

  typedef enum logic [1:0] {IDLE, CHECK, DATA, DONE} state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  if (NUM_TAGS * MAX_BEATS > 2**ADDR_WIDTH || TIMEOUT_CYCLES < 2) begin : g_cfg_check
    $error("pcie_msg_reassembler: invalid parameter combination");
  end

  state_t              state, state_nxt;
  logic [TAG_W-1:0]    h_tag;
  logic [BEAT_W-1:0]   h_offset;
  logic [BEAT_W:0]     h_len;
  logic                h_last;
  logic [1:0]          frag_err;
  logic [BEAT_W:0]     beat_cnt, frag_beats;

  logic [NUM_TAGS-1:0] ctx_active, ctx_have_last;
  logic [BEAT_W:0]     ctx_rcv   [NUM_TAGS];
  logic [BEAT_W:0]     ctx_total [NUM_TAGS];

  logic [BEAT_W:0]     beat_next, end_sum, rcv_new;
  logic                overflow, beat_acc, frag_end, len_hit;
  logic                done_asm, done_err;
  logic [1:0]          done_code;
  logic                tmo_fire;
  logic [TAG_W-1:0]    tmo_tag;

  // end_sum is one bit wider than the offset so offset+len never wraps
  always_comb begin
    beat_next = beat_cnt + (BEAT_W+1)'(1);
    end_sum   = {1'b0, h_offset} + h_len;
    overflow  = end_sum > (BEAT_W+1)'(MAX_BEATS);
    beat_acc  = (state == DATA) && d_valid;
    len_hit   = beat_next == h_len;
    frag_end  = beat_acc && (d_last || len_hit);
    rcv_new   = ctx_rcv[h_tag] + frag_beats;
  end

  always_comb begin
    done_asm  = 1'b0;
    done_err  = 1'b0;
    done_code = ERR_NONE;
    if (state == DONE) begin
      if (frag_err != ERR_NONE) begin
        done_err  = 1'b1;
        done_code = frag_err;
      end else if (ctx_active[h_tag] && ctx_have_last[h_tag]) begin
        if (rcv_new == ctx_total[h_tag]) begin
          done_asm = 1'b1;
        end else if (rcv_new > ctx_total[h_tag]) begin
          done_err  = 1'b1;
          done_code = ERR_LEN;
        end
      end
    end
  end

`ifdef PCIE_REASM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0]    tmo_cnt [NUM_TAGS];
  logic [NUM_TAGS-1:0] tmo_pend;

  // Timer restarts whenever DONE touches the tag, so DONE beats a same-cycle timeout
  always_ff @(posedge clk) begin
    for (int t = 0; t < NUM_TAGS; t++) begin
      if (rst || !ctx_active[t] || (state == DONE && h_tag == TAG_W'(t)))
        tmo_cnt[t] <= '0;
      else if (tmo_cnt[t] != TMO_LIM)
        tmo_cnt[t] <= tmo_cnt[t] + TMO_W'(1);
    end
  end

  always_comb begin
    tmo_pend = '0;
    tmo_tag  = '0;
    for (int t = 0; t < NUM_TAGS; t++)
      tmo_pend[t] = ctx_active[t] && (tmo_cnt[t] == TMO_LIM) &&
                    !(state == DONE && h_tag == TAG_W'(t));
    for (int t = NUM_TAGS - 1; t >= 0; t--)
      if (tmo_pend[t]) tmo_tag = TAG_W'(t);
    tmo_fire = (|tmo_pend) && !done_err;
  end
`else
  assign tmo_fire = 1'b0;
  assign tmo_tag  = '0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hdr_valid) state_nxt = CHECK;
      CHECK:   state_nxt = DATA;
      DATA:    if (frag_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    hdr_ready = !rst && (state == IDLE);
    d_ready   = !rst && (state == DATA);
    asm_valid = 1'b0;
    asm_tag   = '0;
    asm_len   = '0;
    err_valid = 1'b0;
    err_tag   = '0;
    err_code  = ERR_NONE;
    if (!rst) begin
      if (done_asm) begin
        asm_valid = 1'b1;
        asm_tag   = h_tag;
        asm_len   = ctx_total[h_tag];
      end
      if (done_err) begin
        err_valid = 1'b1;
        err_tag   = h_tag;
        err_code  = done_code;
      end else if (tmo_fire) begin
        err_valid = 1'b1;
        err_tag   = tmo_tag;
        err_code  = ERR_TMO;
      end
    end
  end

  // Overflowed fragments keep frag_err=OVF through DATA so their beats are drained unwritten
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      h_tag         <= '0;
      h_offset      <= '0;
      h_len         <= '0;
      h_last        <= 1'b0;
      frag_err      <= ERR_NONE;
      beat_cnt      <= '0;
      frag_beats    <= '0;
      sram_wen      <= 1'b0;
      sram_waddr    <= '0;
      sram_wdata    <= '0;
      ctx_active    <= '0;
      ctx_have_last <= '0;
      for (int t = 0; t < NUM_TAGS; t++) begin
        ctx_rcv[t]   <= '0;
        ctx_total[t] <= '0;
      end
    end else begin
      state    <= state_nxt;
      sram_wen <= 1'b0;
      case (state)
        IDLE: if (hdr_valid) begin
          h_tag    <= hdr_tag;
          h_offset <= hdr_offset;
          h_len    <= hdr_len;
          h_last   <= hdr_last;
        end
        CHECK: begin
          beat_cnt <= '0;
          if (overflow) begin
            frag_err <= ERR_OVF;
          end else begin
            frag_err          <= ERR_NONE;
            ctx_active[h_tag] <= 1'b1;
            if (h_last) begin
              ctx_total[h_tag]     <= end_sum;
              ctx_have_last[h_tag] <= 1'b1;
            end
          end
        end
        DATA: if (beat_acc) begin
          beat_cnt <= beat_next;
          if (frag_err != ERR_OVF) begin
            sram_wen   <= 1'b1;
            sram_waddr <= ADDR_WIDTH'(h_tag) * ADDR_WIDTH'(MAX_BEATS) +
                          ADDR_WIDTH'(h_offset) + ADDR_WIDTH'(beat_cnt);
            sram_wdata <= d_data;
          end
          if (frag_end) begin
            frag_beats <= beat_next;
            if (frag_err == ERR_NONE && (d_last != len_hit)) frag_err <= ERR_LEN;
          end
        end
        DONE: begin
          if (done_asm || done_err) begin
            ctx_active[h_tag]    <= 1'b0;
            ctx_have_last[h_tag] <= 1'b0;
            ctx_rcv[h_tag]       <= '0;
            ctx_total[h_tag]     <= '0;
          end else if (ctx_active[h_tag]) begin
            ctx_rcv[h_tag] <= rcv_new;
          end
        end
        default: ;
      endcase
      if (tmo_fire) begin
        ctx_active[tmo_tag]    <= 1'b0;
        ctx_have_last[tmo_tag] <= 1'b0;
        ctx_rcv[tmo_tag]       <= '0;
        ctx_total[tmo_tag]     <= '0;
      end
    end
  end

endmodule
